// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin port arbiter: default sizing,
// FSM state encoding and a reference round-robin search.
package arb_pkg;

  localparam int ARB_N_REQ    = 4;
  localparam int ARB_MAX_HOLD = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Winner index for up to 16 requesters, searching upward from ptr+1 with
  // wrap-around; returns ptr when nothing is requesting.
  function automatic int rr_pick(input logic [15:0] req, input int ptr,
                                 input int n = ARB_N_REQ);
    int idx;
    rr_pick = ptr;
    for (int k = n; k >= 1; k--) begin
      idx = (ptr + k) % n;
      if (req[idx[3:0]]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin search: rotate the request vector so the entry
// after ptr sits at bit 0, find the first set bit, then map back to an index.
module rr_priority_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic            valid_o,
  output logic [ID_W-1:0] idx_o
);

  localparam int            DBL_W = 2 ** (ID_W + 1);
  localparam logic [ID_W:0] LAST  = (ID_W + 1)'(N - 1);
  localparam logic [ID_W:0] ONE   = (ID_W + 1)'(1);

  logic [ID_W:0]  start;
  logic [DBL_W-1:0] req_dbl;
  logic [N-1:0]   rot;
  logic [ID_W:0]  off;
  logic [ID_W:0]  sum;

  always_comb begin
    if ({1'b0, ptr_i} == LAST) start = '0;
    else                       start = {1'b0, ptr_i} + ONE;
  end

  // Two copies back to back let the rotation index run past N without a modulo.
  assign req_dbl = DBL_W'({req_i, req_i});

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      logic [ID_W:0] pos;
      assign pos     = start + (ID_W + 1)'(gi);
      assign rot[gi] = req_dbl[pos];
    end
  endgenerate

  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = (ID_W + 1)'(k);
    end
  end

  assign valid_o = |rot;
  assign sum     = start + off;

  always_comb begin
    idx_o = '0;
    for (int j = 0; j < N; j++) begin
      if (sum == (ID_W + 1)'(j) || sum == (ID_W + 1)'(j + N)) idx_o = ID_W'(j);
    end
  end

endmodule

// File: rtl/shared_port_arbiter.sv
// Round-robin arbiter sharing one downstream port among N_REQ requesters.
// Optional grant hold limit enabled by defining SHARED_PORT_ARB_TIMEOUT_EN.
module shared_port_arbiter
  import arb_pkg::*;
#(
  parameter int  N_REQ    = ARB_N_REQ,
  parameter int  MAX_HOLD = ARB_MAX_HOLD,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_done,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_grant_valid,
  output logic [ID_W-1:0]  o_grant_id,
  output logic             o_busy,
  output logic             o_timeout
);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;

  logic             pick_valid;
  logic [ID_W-1:0]  pick_idx;
  logic             owner_req;
  logic             expire;

  rr_priority_pick #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req_i   (i_req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Owner still requesting; grant_q is one-hot so no index decode is needed.
  assign owner_req = |(i_req & grant_q);

`ifdef SHARED_PORT_ARB_TIMEOUT_EN
  localparam int              HOLD_W    = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;

  assign expire = (hold_q == HOLD_LAST);
`else
  // MAX_HOLD has no effect without the hold limit compiled in.
  if (MAX_HOLD < 1) begin : g_max_hold_unused
  end
  assign expire = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= ID_W'(N_REQ - 1);
`ifdef SHARED_PORT_ARB_TIMEOUT_EN
      hold_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
`ifdef SHARED_PORT_ARB_TIMEOUT_EN
      hold_q     <= hold_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
`ifdef SHARED_PORT_ARB_TIMEOUT_EN
    hold_d     = hold_q;
    timeout_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = GRANT;
          grant_d    = N_REQ'(1) << pick_idx;
          grant_id_d = pick_idx;
          ptr_d      = pick_idx;
`ifdef SHARED_PORT_ARB_TIMEOUT_EN
          hold_d     = '0;
`endif
        end
      end
      GRANT: begin
`ifdef SHARED_PORT_ARB_TIMEOUT_EN
        hold_d = hold_q + HOLD_W'(1);
`endif
        if (i_done || !owner_req || expire) begin
          state_d = RELEASE;
          grant_d = '0;
`ifdef SHARED_PORT_ARB_TIMEOUT_EN
          // A completion in the expiry cycle is a normal release, not a timeout.
          timeout_d = expire && !i_done;
`endif
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_grant       = grant_q;
    o_grant_valid = |grant_q;
    o_grant_id    = grant_id_q;
    o_busy        = (state_q == GRANT) || (state_q == RELEASE);
`ifdef SHARED_PORT_ARB_TIMEOUT_EN
    o_timeout     = timeout_q;
`else
    o_timeout     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_shared_port_arbiter.sv
// Self-checking bench for shared_port_arbiter: directed scenarios plus a
// randomized run against a behavioural owner/bubble/pointer model.
module tb_shared_port_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;
`ifdef SHARED_PORT_ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic         i_clk;
  logic         i_rst_n;
  logic [N-1:0] i_req;
  logic         i_done;
  logic [N-1:0] o_grant;
  logic         o_grant_valid;
  logic [1:0]   o_grant_id;
  logic         o_busy;
  logic         o_timeout;

  int total;
  int bad;

  // Reference model: current owner (-1 none), pending bubble, pointer, hold.
  int m_owner;
  int m_ptr;
  int m_last_id;
  int m_hold;
  bit m_bubble;
  bit m_timeout;

  shared_port_arbiter #(
    .N_REQ    (N),
    .MAX_HOLD (MH)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req         (i_req),
    .i_done        (i_done),
    .o_grant       (o_grant),
    .o_grant_valid (o_grant_valid),
    .o_grant_id    (o_grant_id),
    .o_busy        (o_busy),
    .o_timeout     (o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic int model_pick(input logic [N-1:0] req, input int ptr);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (ptr + k) % N;
      if (req[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_ptr     = N - 1;
    m_last_id = 0;
    m_hold    = 0;
    m_bubble  = 1'b0;
    m_timeout = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic done);
    int  w;
    bit  exp_hit;
    m_timeout = 1'b0;
    if (m_owner >= 0) begin
      exp_hit = TO && (m_hold == MH);
      if (done || !req[m_owner[1:0]] || exp_hit) begin
        m_timeout = exp_hit && !done;
        m_owner   = -1;
        m_bubble  = 1'b1;
      end else begin
        m_hold++;
      end
    end else if (m_bubble) begin
      m_bubble = 1'b0;
    end else begin
      w = model_pick(req, m_ptr);
      if (w >= 0) begin
        m_owner   = w;
        m_ptr     = w;
        m_last_id = w;
        m_hold    = 1;
      end
    end
  endtask

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner[1:0]] = 1'b1;
    return g;
  endfunction

  task automatic step(input logic [N-1:0] req, input logic done);
    i_req  = req;
    i_done = done;
    @(posedge i_clk);
    #1;
    model_step(req, done);
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0;
    i_req   = '0;
    i_done  = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({o_grant, o_grant_valid, o_grant_id, o_busy, o_timeout} !== 9'b0) begin
      bad++;
      $display("FAIL reset_outputs got grant=%b v=%b id=%0d busy=%b to=%b want all zero",
               o_grant, o_grant_valid, o_grant_id, o_busy, o_timeout);
    end
    step(4'b0000, 1'b1);
    total++;
    if (o_grant !== 4'b0000 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_req got grant=%b busy=%b want grant=0000 busy=0", o_grant, o_busy);
    end
  endtask

  task automatic test_single();
    apply_reset();
    step(4'b0001, 1'b0);
    total++;
    if (o_grant !== 4'b0001 || o_grant_id !== 2'd0 || o_grant_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_grant got grant=%b id=%0d v=%b want grant=0001 id=0 v=1",
               o_grant, o_grant_id, o_grant_valid);
    end
    step(4'b0001, 1'b1);
    total++;
    if (o_grant !== 4'b0000 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL single_release got grant=%b busy=%b want grant=0000 busy=1", o_grant, o_busy);
    end
    step(4'b0001, 1'b0);
    total++;
    if (o_grant !== 4'b0000 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle got grant=%b busy=%b want grant=0000 busy=0", o_grant, o_busy);
    end
    step(4'b0001, 1'b0);
    total++;
    if (o_grant !== 4'b0001) begin
      bad++;
      $display("FAIL single_regrant got grant=%b want grant=0001", o_grant);
    end
    $display("single requester regranted id=%0d", o_grant_id);
  endtask

  task automatic test_round_robin();
    logic [1:0] order [5];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    apply_reset();
    for (int r = 0; r < 5; r++) begin
      step(4'b1111, 1'b0);
      total++;
      if (o_grant_id !== order[r] || o_grant !== (4'b0001 << order[r])) begin
        bad++;
        $display("FAIL rr_order[%0d] got id=%0d grant=%b want id=%0d", r, o_grant_id, o_grant, order[r]);
      end
      $display("rr grant %0d -> id=%0d", r, o_grant_id);
      step(4'b1111, 1'b1);
      step(4'b1111, 1'b0);
      total++;
      if (o_grant !== 4'b0000) begin
        bad++;
        $display("FAIL rr_gap[%0d] got grant=%b want 0000", r, o_grant);
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    step(4'b1000, 1'b0);
    total++;
    if (o_grant_id !== 2'd3) begin
      bad++;
      $display("FAIL wrap_first got id=%0d want 3", o_grant_id);
    end
    step(4'b1001, 1'b1);
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b0);
    total++;
    if (o_grant !== 4'b0001 || o_grant_id !== 2'd0) begin
      bad++;
      $display("FAIL wrap_to_zero got grant=%b id=%0d want grant=0001 id=0", o_grant, o_grant_id);
    end
    step(4'b1001, 1'b1);
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b0);
    total++;
    if (o_grant !== 4'b1000 || o_grant_id !== 2'd3) begin
      bad++;
      $display("FAIL wrap_next got grant=%b id=%0d want grant=1000 id=3", o_grant, o_grant_id);
    end
    $display("wrap sequence ended on id=%0d", o_grant_id);
  endtask

  task automatic test_drop();
    apply_reset();
    step(4'b0100, 1'b0);
    total++;
    if (o_grant !== 4'b0100) begin
      bad++;
      $display("FAIL drop_owner got grant=%b want 0100", o_grant);
    end
    step(4'b0110, 1'b0);
    total++;
    if (o_grant !== 4'b0100) begin
      bad++;
      $display("FAIL drop_nonowner_ignored got grant=%b want 0100", o_grant);
    end
    step(4'b0010, 1'b0);
    total++;
    if (o_grant !== 4'b0000 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL drop_release got grant=%b busy=%b want grant=0000 busy=1", o_grant, o_busy);
    end
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    total++;
    if (o_grant !== 4'b0010 || o_grant_id !== 2'd1) begin
      bad++;
      $display("FAIL drop_regrant got grant=%b id=%0d want grant=0010 id=1", o_grant, o_grant_id);
    end
    $display("drop release then grant id=%0d", o_grant_id);
  endtask

  task automatic test_hold_limit();
    apply_reset();
    step(4'b0010, 1'b0);
`ifdef SHARED_PORT_ARB_TIMEOUT_EN
    for (int c = 1; c <= MH; c++) begin
      step(4'b0010, 1'b0);
      total++;
      if (c < MH && (o_grant !== 4'b0010 || o_timeout !== 1'b0)) begin
        bad++;
        $display("FAIL timeout_hold[%0d] got grant=%b to=%b want grant=0010 to=0", c, o_grant, o_timeout);
      end else if (c == MH && (o_grant !== 4'b0000 || o_timeout !== 1'b1)) begin
        bad++;
        $display("FAIL timeout_fire got grant=%b to=%b want grant=0000 to=1", o_grant, o_timeout);
      end
    end
    step(4'b0010, 1'b0);
    total++;
    if (o_timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_pulse_width got to=%b want 0", o_timeout);
    end
    step(4'b0010, 1'b0);
    for (int c = 1; c <= MH; c++) begin
      step(4'b0010, (c == MH));
      total++;
      if (c == MH && (o_grant !== 4'b0000 || o_timeout !== 1'b0)) begin
        bad++;
        $display("FAIL timeout_done_wins got grant=%b to=%b want grant=0000 to=0", o_grant, o_timeout);
      end else if (c < MH && o_grant !== 4'b0010) begin
        bad++;
        $display("FAIL timeout_hold2[%0d] got grant=%b want 0010", c, o_grant);
      end
    end
    $display("timeout scenarios complete");
`else
    for (int c = 1; c <= 3 * MH; c++) begin
      step(4'b0010, 1'b0);
      total++;
      if (o_grant !== 4'b0010 || o_timeout !== 1'b0) begin
        bad++;
        $display("FAIL hold_forever[%0d] got grant=%b to=%b want grant=0010 to=0", c, o_grant, o_timeout);
      end
    end
    $display("grant held %0d cycles without limit", 3 * MH);
`endif
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(4'b0100, 1'b0);
    #3;
    i_rst_n = 1'b0;
    #1;
    total++;
    if (o_grant !== 4'b0000 || o_busy !== 1'b0 || o_grant_id !== 2'd0 || o_grant_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got grant=%b busy=%b id=%0d v=%b want all zero",
               o_grant, o_busy, o_grant_id, o_grant_valid);
    end
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step(4'b1111, 1'b0);
    total++;
    if (o_grant !== 4'b0001) begin
      bad++;
      $display("FAIL async_reset_ptr got grant=%b want 0001", o_grant);
    end
    $display("post-reset grant id=%0d", o_grant_id);
  endtask

  task automatic test_random();
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] prev_grant;
    logic [N-1:0] exp_grant;
    apply_reset();
    req        = '0;
    prev_grant = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      done = ($urandom_range(0, 4) == 0);
      step(req, done);
      exp_grant = model_grant();
      total++;
      if (o_grant !== exp_grant || o_grant_id !== m_last_id[1:0] || o_busy !== (m_owner >= 0 || m_bubble) ||
          o_grant_valid !== (m_owner >= 0) || o_timeout !== m_timeout) begin
        bad++;
        $display("FAIL random[%0d] got grant=%b id=%0d busy=%b to=%b want grant=%b id=%0d busy=%b to=%b",
                 c, o_grant, o_grant_id, o_busy, o_timeout, exp_grant, m_last_id,
                 (m_owner >= 0 || m_bubble), m_timeout);
      end
      if (o_grant !== prev_grant && o_grant_valid)
        $display("random cycle %0d grant id=%0d req=%b", c, o_grant_id, req);
      prev_grant = o_grant;
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    i_rst_n = 1'b0;
    i_req   = '0;
    i_done  = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_drop();
    test_hold_limit();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
